path_gnt_arbiter: RTL and testbench
===================================

// Module: path_gnt_arbiter
// PURPOSE
// - Grant-side responder for the path req/gnt protocol: accepts req from NREQ path
//   instances, issues single-cycle gnt to one, captures that path's data on the grant.
// - Round-robin selection gives every steady requester a grant within NREQ grants;
//   granted words leave through a one-entry valid/ready output stage to the consumer.
// PARAMETERS
// - DWIDTH   8    data width per path
// - NREQ     4    number of requesting paths (2..16)
// - MAX_WAIT 15   starvation bound in cycles (used only with PATH_ARB_WAIT_MON_EN)
// PORTS
// - clk           in   1            rising-edge clock
// - rst_n         in   1            synchronous, active-low reset
// - req_i         in   NREQ         per-path request; level, held until granted
// - data_i        in   NREQ*DWIDTH  per-path data; slice i valid while req_i[i]
// - gnt_o         out  NREQ         one-hot or zero grant, combinational
// - out_valid_o   out  1            output word valid
// - out_data_o    out  DWIDTH       captured word
// - out_src_o     out  $clog2(NREQ) index of path that produced out_data_o
// - out_ready_i   in   1            consumer accepts word when out_valid_o && out_ready_i
// - starve_err_o  out  1            sticky starvation flag (only with macro)
// BEHAVIOUR
// - Reset: out_valid_o=0, out_data_o=0, out_src_o=0, rr pointer=0, wait counters=0,
//   starve_err_o=0. gnt_o=0 during reset cycle regardless of req_i.
// - can_take = !out_valid_o || out_ready_i (stage empty or draining this cycle).
// - gnt_o[i]=1 iff can_take && req_i[i] && i is first requester at/after rr pointer
//   (wrap at NREQ-1 -> 0). Hence gnt_o[i] implies req_i[i]; at most one bit set.
// - Same-cycle bypass: granting path's data is on data_i at grant edge; captured into
//   out_data_o, out_src_o=i, out_valid_o=1 next cycle (latency 1 gnt->out_valid).
// - Pointer update on grant to i: ptr <= (i==NREQ-1) ? 0 : i+1. No grant: ptr holds.
// - Out stage: accept w/o new grant -> out_valid_o<=0; accept + grant -> new word,
//   valid stays 1 (full throughput, one word/cycle); no accept -> word, src held.
// - out_ready_i=0 with out_valid_o=1: no grants, requests wait (backpressure).
// - No requests: gnt_o=0, pointer held, out stage drains normally.
// - req_i dropping without grant is legal; that path simply stops competing.
// - Reset mid-transfer: held word discarded; no grant in reset cycle.
// CONFIGURATION
// - PATH_ARB_WAIT_MON_EN defined: per-path wait counter (width $clog2(MAX_WAIT+1)+1)
//   increments while req_i[i]&&!gnt_o[i], clears on grant or !req_i[i], saturates;
//   count > MAX_WAIT sets starve_err_o sticky until reset.
// - Not defined: counters and starve_err_o port absent; arbitration identical.
// STRUCTURE
// - path_arb_pkg: IDX_W function/localparam ($clog2), typedef idx_t, rr_next() helper.
// - Sub-module rr_pick: combinational round-robin picker (req vector, ptr in;
//   one-hot grant, index, any-valid out). Top holds pointer, out stage, monitor.
// TESTING
// - req_i=4'b0001, data slice0=8'hA5, ready=1 -> gnt_o=0001 same cycle;
//   next cycle out_valid_o=1, out_data_o=A5, out_src_o=0; ptr=1.
// - req_i=4'b1111 held, ready=1 -> gnts 0001,0010,0100,1000,0001 on consecutive
//   cycles; out_src_o 0,1,2,3,0 one cycle later.
// - Word held, ready=0 for 5 cycles with req_i=4'b0110 -> gnt_o=0 all 5 cycles,
//   out_data_o stable; ready=1 -> gnt_o=0010 same cycle, new word next cycle.
// - Pointer at 3, req_i=4'b0101 -> gnt_o=0001 (wrap), ptr becomes 1; then 0100.
// - rst_n=0 while out_valid_o=1, req_i=4'b1111 -> gnt_o=0, next cycle out_valid_o=0,
//   first post-reset grant to path 0.
// - Macro on, MAX_WAIT=3, req_i[2]=1 held, ready=0 -> starve_err_o=1 after 4 waiting
//   cycles, stays 1 after ready=1 until rst_n=0.

Source files
------------

// File: rtl/path_arb_pkg.sv
// Shared sizing helpers and the round-robin pointer step for path_gnt_arbiter.
package path_arb_pkg;

  localparam int MAX_NREQ = 16;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [$clog2(MAX_NREQ)-1:0] idx_t;

  // Pointer moves just past the granted path, wrapping at the last one.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/path_gnt_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester at/after ptr_i wins.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any_o && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/path_gnt_arbiter.sv
// Round-robin grant responder with a one-entry valid/ready output stage.
// Optional starvation monitor enabled by defining PATH_ARB_WAIT_MON_EN.
module path_gnt_arbiter
  import path_arb_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int NREQ     = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*DWIDTH-1:0]   data_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic                     out_valid_o,
  output logic [DWIDTH-1:0]        out_data_o,
  output logic [idx_w(NREQ)-1:0]   out_src_o,
  input  logic                     out_ready_i
`ifdef PATH_ARB_WAIT_MON_EN
  ,
  output logic                     starve_err_o
`endif
);

  localparam int IW = idx_w(NREQ);

  if (NREQ < 2 || NREQ > MAX_NREQ || MAX_WAIT < 1) begin : g_param_err
    $error("path_gnt_arbiter: NREQ must be 2..16 and MAX_WAIT >= 1");
  end

  logic [IW-1:0]     ptr_q, ptr_d;
  logic              vld_p0_q, vld_p0_d;
  logic [DWIDTH-1:0] data_p0_q, data_p0_d;
  logic [IW-1:0]     src_p0_q, src_p0_d;
  logic              can_take;
  logic [NREQ-1:0]   req_eff;
  logic [NREQ-1:0]   pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  idx_t              ptr_step;

  // Requests are masked while in reset or while the held word cannot move.
  assign can_take = !vld_p0_q || out_ready_i;
  assign req_eff  = (rst_n && can_take) ? req_i : '0;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i (req_eff),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign gnt_o = pick_gnt;

  always_comb begin
    ptr_step  = idx_t'(rr_next(int'(pick_idx), NREQ));
    ptr_d     = ptr_q;
    vld_p0_d  = vld_p0_q;
    data_p0_d = data_p0_q;
    src_p0_d  = src_p0_q;
    if (pick_any) begin
      ptr_d     = IW'(ptr_step);
      vld_p0_d  = 1'b1;
      data_p0_d = data_i[int'(pick_idx)*DWIDTH +: DWIDTH];
      src_p0_d  = pick_idx;
    end else if (out_ready_i) begin
      vld_p0_d  = 1'b0;
    end
  end

  // Stage p0: captured word, source index and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      vld_p0_q  <= 1'b0;
      data_p0_q <= '0;
      src_p0_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      vld_p0_q  <= vld_p0_d;
      data_p0_q <= data_p0_d;
      src_p0_q  <= src_p0_d;
    end
  end

  assign out_valid_o = vld_p0_q;
  assign out_data_o  = data_p0_q;
  assign out_src_o   = src_p0_q;

`ifdef PATH_ARB_WAIT_MON_EN
  localparam int CW = idx_w(MAX_WAIT + 1) + 1;

  logic [CW-1:0] wait_q [NREQ];
  logic [CW-1:0] wait_d [NREQ];
  logic          starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    for (int i = 0; i < NREQ; i++) begin
      wait_d[i] = '0;
      if (req_i[i] && !gnt_o[i])
        wait_d[i] = (wait_q[i] == '1) ? wait_q[i] : wait_q[i] + 1'b1;
      if (int'(wait_d[i]) > MAX_WAIT) starve_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= 1'b0;
      for (int i = 0; i < NREQ; i++) wait_q[i] <= '0;
    end else begin
      starve_q <= starve_d;
      for (int i = 0; i < NREQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign starve_err_o = starve_q;
`endif

endmodule

// File: tb/tb_path_gnt_arbiter.sv
// Directed vector bench for path_gnt_arbiter (NREQ=4, DWIDTH=8, MAX_WAIT=3).
module tb_path_gnt_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  gnt_o;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic [1:0]  out_src_o;
  logic        out_ready_i;
`ifdef PATH_ARB_WAIT_MON_EN
  logic        starve_err_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  path_gnt_arbiter #(.DWIDTH(8), .NREQ(4), .MAX_WAIT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .data_i      (data_i),
    .gnt_o       (gnt_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_src_o   (out_src_o),
    .out_ready_i (out_ready_i)
`ifdef PATH_ARB_WAIT_MON_EN
    ,
    .starve_err_o(starve_err_o)
`endif
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic        ready;
    logic [3:0]  exp_gnt;
    logic        exp_vld;
    logic [7:0]  exp_data;
    logic [1:0]  exp_src;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input string n, input logic r, input logic [3:0] q,
                              input logic [31:0] d, input logic rd, input logic [3:0] g,
                              input logic v, input logic [7:0] od, input logic [1:0] os);
    vec_t t;
    t.name = n; t.rst_n = r; t.req = q; t.data = d; t.ready = rd;
    t.exp_gnt = g; t.exp_vld = v; t.exp_data = od; t.exp_src = os;
    vecs.push_back(t);
  endfunction

  // Inputs change 1 time unit after a rising edge; gnt checked 1 unit later,
  // registered outputs checked 1 unit after the following rising edge.
  task automatic apply(input vec_t t);
    rst_n = t.rst_n; req_i = t.req; data_i = t.data; out_ready_i = t.ready;
    #1;
    chk({t.name, ".gnt"}, 32'(gnt_o), 32'(t.exp_gnt));
    @(posedge clk); #1;
    chk({t.name, ".vld"},  32'(out_valid_o), 32'(t.exp_vld));
    chk({t.name, ".data"}, 32'(out_data_o),  32'(t.exp_data));
    chk({t.name, ".src"},  32'(out_src_o),   32'(t.exp_src));
  endtask

  localparam logic [31:0] ALL = 32'hD3C2B1A0;

  initial begin
    rst_n = 1'b0; req_i = '0; data_i = '0; out_ready_i = 1'b1;
    @(posedge clk); #1;

    //   name       rst  req      data          rdy  gnt      vld  data   src
    add("rst0",     0, 4'b1111, ALL,          1, 4'b0000, 0, 8'h00, 2'd0);
    add("rr0",      1, 4'b1111, ALL,          1, 4'b0001, 1, 8'hA0, 2'd0);
    add("rr1",      1, 4'b1111, ALL,          1, 4'b0010, 1, 8'hB1, 2'd1);
    add("rr2",      1, 4'b1111, ALL,          1, 4'b0100, 1, 8'hC2, 2'd2);
    add("rr3",      1, 4'b1111, ALL,          1, 4'b1000, 1, 8'hD3, 2'd3);
    add("rr4",      1, 4'b1111, ALL,          1, 4'b0001, 1, 8'hA0, 2'd0);
    add("single",   1, 4'b0001, 32'h000000A5, 1, 4'b0001, 1, 8'hA5, 2'd0);
    add("drain",    1, 4'b0000, 32'h0,        1, 4'b0000, 0, 8'hA5, 2'd0);
    add("load2",    1, 4'b0100, 32'h00770000, 1, 4'b0100, 1, 8'h77, 2'd2);
    for (int i = 0; i < 5; i++)
      add("bp",     1, 4'b0110, 32'h00221100, 0, 4'b0000, 1, 8'h77, 2'd2);
    add("bp_rel",   1, 4'b0110, 32'h00221100, 1, 4'b0010, 1, 8'h11, 2'd1);
    add("to_p3",    1, 4'b0100, 32'h00440000, 1, 4'b0100, 1, 8'h44, 2'd2);
    add("wrap",     1, 4'b0101, 32'h00520050, 1, 4'b0001, 1, 8'h50, 2'd0);
    add("after_wr", 1, 4'b0101, 32'h00520050, 1, 4'b0100, 1, 8'h52, 2'd2);
    add("rst_mid",  0, 4'b1111, ALL,          1, 4'b0000, 0, 8'h00, 2'd0);
    add("post_rst", 1, 4'b1111, ALL,          1, 4'b0001, 1, 8'hA0, 2'd0);
    add("hold",     1, 4'b0000, ALL,          0, 4'b0000, 1, 8'hA0, 2'd0);
    add("drain2",   1, 4'b0000, ALL,          1, 4'b0000, 0, 8'hA0, 2'd0);

    foreach (vecs[i]) apply(vecs[i]);

`ifdef PATH_ARB_WAIT_MON_EN
    rst_n = 1'b0; req_i = '0; out_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("starve.rst", 32'(starve_err_o), 32'd0);
    rst_n = 1'b1; req_i = 4'b0001; data_i = 32'h0000005A;
    @(posedge clk); #1;
    req_i = 4'b0100; out_ready_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk("starve.early", 32'(starve_err_o), 32'd0);
    end
    @(posedge clk); #1;
    chk("starve.set", 32'(starve_err_o), 32'd1);
    req_i = 4'b0000; out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("starve.sticky", 32'(starve_err_o), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("starve.clr", 32'(starve_err_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
